// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetches and MEM loads/stores.
// MEM wins by default, IF is forced through after STARVE_LIMIT lost rounds, WAIT is bounded.
module mem_port_arbiter #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [WORD_LEN-1:0] if_addr,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [WORD_LEN-1:0] mem_addr,
    input  logic [WORD_LEN-1:0] mem_wdata,
    output logic                ram_req,
    output logic                ram_we,
    output logic [WORD_LEN-1:0] ram_addr,
    output logic [WORD_LEN-1:0] ram_wdata,
    input  logic [WORD_LEN-1:0] ram_rdata,
    input  logic                ram_ready,
    output logic [WORD_LEN-1:0] if_rdata,
    output logic                if_valid,
    output logic [WORD_LEN-1:0] mem_rdata,
    output logic                mem_valid,
    output logic                err,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                ram_req_q, ram_req_d;
    logic                ram_we_q, ram_we_d;
    logic [WORD_LEN-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_LEN-1:0] ram_wdata_q, ram_wdata_d;
    logic [WORD_LEN-1:0] if_rdata_q, if_rdata_d;
    logic [WORD_LEN-1:0] mem_rdata_q, mem_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic                mem_valid_q, mem_valid_d;
    logic                err_q, err_d;
    logic                gnt_mem_q, gnt_mem_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic [7:0]          tmo_cnt_q, tmo_cnt_d;
    logic                mem_pend;
    logic [WORD_LEN-1:0] rdata_sel;

    assign mem_pend = mem_r_en | mem_w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ram_req_q    <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_valid_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            gnt_mem_q    <= 1'b0;
            starve_cnt_q <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ram_req_q    <= ram_req_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_valid_q   <= if_valid_d;
            mem_valid_q  <= mem_valid_d;
            err_q        <= err_d;
            gnt_mem_q    <= gnt_mem_d;
            starve_cnt_q <= starve_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ram_req_d    = ram_req_q;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_valid_d   = 1'b0;
        mem_valid_d  = 1'b0;
        err_d        = 1'b0;
        gnt_mem_d    = gnt_mem_q;
        starve_cnt_d = starve_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        rdata_sel    = '0;
        case (state_q)
            StIdle: begin
                if (mem_pend && (!if_req || starve_cnt_q < StarveMax)) begin
                    gnt_mem_d    = 1'b1;
                    ram_addr_d   = mem_addr;
                    ram_we_d     = mem_w_en;
                    ram_wdata_d  = mem_wdata;
                    starve_cnt_d = if_req ? starve_cnt_q + 4'd1 : 4'd0;
                    ram_req_d    = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = StWait;
                end else if (if_req) begin
                    gnt_mem_d    = 1'b0;
                    ram_addr_d   = if_addr;
                    ram_we_d     = 1'b0;
                    starve_cnt_d = '0;
                    ram_req_d    = 1'b1;
                    tmo_cnt_d    = '0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (ram_ready || tmo_cnt_q == TmoLast) begin
                    // An aborted read returns zero instead of whatever sits on the bus.
                    rdata_sel = ram_ready ? ram_rdata : '0;
                    if (gnt_mem_q) begin
                        if (!ram_we_q) mem_rdata_d = rdata_sel;
                        mem_valid_d = 1'b1;
                    end else begin
                        if_rdata_d = rdata_sel;
                        if_valid_d = 1'b1;
                    end
                    err_d     = !ram_ready;
                    ram_req_d = 1'b0;
                    state_d   = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_req   = ram_req_q;
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        if_rdata  = if_rdata_q;
        mem_rdata = mem_rdata_q;
        if_valid  = if_valid_q;
        mem_valid = mem_valid_q;
        err       = err_q;
        stall_if  = !rst && if_req && !if_valid_q;
        stall_mem = !rst && mem_pend && !mem_valid_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level schedule model and a responding memory.
module tb_mem_port_arbiter;
    localparam int unsigned W    = 32;
    localparam int unsigned TMO  = 15;
    localparam int unsigned SLIM = 4;

    logic         clk = 1'b0;
    logic         rst, if_req, mem_r_en, mem_w_en, ram_req, ram_we, ram_ready;
    logic         if_valid, mem_valid, err, stall_if, stall_mem;
    logic [W-1:0] if_addr, mem_addr, mem_wdata, ram_addr, ram_wdata, ram_rdata;
    logic [W-1:0] if_rdata, mem_rdata;
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] mmem [logic [W-1:0]];
    logic [W-1:0] rmem [logic [W-1:0]];

    mem_port_arbiter #(.WORD_LEN(W), .TIMEOUT(TMO), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready), .if_rdata(if_rdata), .if_valid(if_valid),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err), .stall_if(stall_if),
        .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(logic [W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; ram_ready = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; ram_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; if_req = 1'b1; mem_r_en = 1'b1; if_addr = 32'h4; mem_addr = 32'h8;
        ram_ready = 1'b1; ram_rdata = 32'h55;
        step(); step();
        n_checks++;
        if ({ram_req, ram_we, if_valid, mem_valid, err, stall_if, stall_mem} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {ram_req, ram_we, if_valid, mem_valid, err, stall_if, stall_mem});
        else n_pass++;
        n_checks++;
        if ({ram_addr, ram_wdata, if_rdata, mem_rdata} !== 128'b0)
            $display("FAIL reset_data: got %h want 0", {ram_addr, ram_wdata, if_rdata, mem_rdata});
        else n_pass++;
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_if_only();
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        n_checks++;
        if (stall_if !== 1'b1) $display("FAIL ifo_stall_c0: got %b want 1", stall_if);
        else n_pass++;
        step();
        n_checks++;
        if ({ram_req, ram_we, ram_addr, stall_if} !== {2'b10, 32'h10, 1'b1})
            $display("FAIL ifo_c1: got %b %b %h %b want 1 0 10 1", ram_req, ram_we, ram_addr,
                     stall_if);
        else n_pass++;
        step();
        n_checks++;
        if ({ram_req, if_valid, stall_if} !== 3'b101)
            $display("FAIL ifo_c2: got %b want 101", {ram_req, if_valid, stall_if});
        else n_pass++;
        ram_ready = 1'b1; ram_rdata = 32'hDEAD_BEEF;
        step();
        ram_ready = 1'b0;
        n_checks++;
        if ({if_valid, mem_valid, err, ram_req, stall_if} !== 5'b10000)
            $display("FAIL ifo_c3_ctrl: got %b want 10000",
                     {if_valid, mem_valid, err, ram_req, stall_if});
        else n_pass++;
        n_checks++;
        if (if_rdata !== 32'hDEAD_BEEF) $display("FAIL ifo_rdata: got %h want deadbeef", if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
        n_checks++;
        if ({if_valid, if_rdata} !== {1'b0, 32'hDEAD_BEEF})
            $display("FAIL ifo_hold: got %b %h want 0 deadbeef", if_valid, if_rdata);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        if_req = 1'b1; if_addr = 32'h20; mem_r_en = 1'b1; mem_addr = 32'h40;
        step();
        n_checks++;
        if ({ram_req, ram_we, ram_addr} !== {2'b10, 32'h40})
            $display("FAIL sim_mem_grant: got %b %b %h want 1 0 40", ram_req, ram_we, ram_addr);
        else n_pass++;
        step();
        ram_ready = 1'b1; ram_rdata = 32'h1234_5678;
        step();
        ram_ready = 1'b0;
        n_checks++;
        if ({mem_valid, if_valid, mem_rdata} !== {2'b10, 32'h1234_5678})
            $display("FAIL sim_mem_done: got %b %b %h want 1 0 12345678", mem_valid, if_valid,
                     mem_rdata);
        else n_pass++;
        mem_r_en = 1'b0;
        step();
        #1;
        n_checks++;
        if ({ram_req, stall_if, stall_mem} !== 3'b010)
            $display("FAIL sim_c4: got %b want 010", {ram_req, stall_if, stall_mem});
        else n_pass++;
        step();
        n_checks++;
        if ({ram_req, ram_addr} !== {1'b1, 32'h20})
            $display("FAIL sim_if_grant: got %b %h want 1 20", ram_req, ram_addr);
        else n_pass++;
        step();
        ram_ready = 1'b1; ram_rdata = 32'hCAFE_0001;
        step();
        ram_ready = 1'b0;
        n_checks++;
        if ({if_valid, if_rdata} !== {1'b1, 32'hCAFE_0001})
            $display("FAIL sim_if_done: got %b %h want 1 cafe0001", if_valid, if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        mem_w_en = 1'b1; mem_addr = 32'h8; mem_wdata = 32'h5;
        step();
        mem_addr = 32'h99; mem_wdata = 32'h77;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({ram_req, ram_we, ram_addr, ram_wdata} !== {2'b11, 32'h8, 32'h5})
                $display("FAIL st_wait%0d: got %b %b %h %h want 1 1 8 5", i, ram_req, ram_we,
                         ram_addr, ram_wdata);
            else n_pass++;
            if (i == 1) begin
                ram_ready = 1'b1; ram_rdata = 32'hFFFF_FFFF;
            end
            step();
        end
        ram_ready = 1'b0;
        n_checks++;
        if ({mem_valid, err, mem_rdata} !== {2'b10, 32'h1234_5678})
            $display("FAIL st_done: got %b %b %h want 1 0 12345678", mem_valid, err, mem_rdata);
        else n_pass++;
        mem_w_en = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        bit           seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int unsigned  m = 0;
        logic [W-1:0] want;
        if_req = 1'b1; if_addr = 32'h100; mem_r_en = 1'b1; mem_addr = 32'h200;
        for (int j = 0; j < 6; j++) begin
            step();
            want = seq[j] ? 32'h200 + 32'(4 * m) : 32'h100;
            n_checks++;
            if ({ram_req, ram_addr} !== {1'b1, want})
                $display("FAIL starve_grant%0d: got %b %h want 1 %h", j, ram_req, ram_addr, want);
            else n_pass++;
            ram_ready = 1'b1; ram_rdata = 32'h1000 + 32'(j);
            step();
            ram_ready = 1'b0;
            n_checks++;
            if ({if_valid, mem_valid} !== (seq[j] ? 2'b01 : 2'b10))
                $display("FAIL starve_valid%0d: got %b%b want %b", j, if_valid, mem_valid,
                         seq[j] ? 2'b01 : 2'b10);
            else n_pass++;
            if (seq[j]) begin
                m++;
                mem_addr = 32'h200 + 32'(4 * m);
            end else begin
                if_req = 1'b0;
            end
            step();
        end
        mem_r_en = 1'b0;
    endtask

    task automatic test_timeout();
        mem_r_en = 1'b1; mem_addr = 32'h44; ram_ready = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            step();
            n_checks++;
            if ({ram_req, mem_valid} !== 2'b10)
                $display("FAIL tmo_wait%0d: got %b want 10", c, {ram_req, mem_valid});
            else n_pass++;
        end
        step();
        n_checks++;
        if ({mem_valid, err, ram_req, mem_rdata} !== {3'b110, 32'h0})
            $display("FAIL tmo_resp: got %b %b %b %h want 1 1 0 0", mem_valid, err, ram_req,
                     mem_rdata);
        else n_pass++;
        mem_r_en = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h77;
        step();
        n_checks++;
        if ({mem_valid, err, ram_req, mem_rdata} !== {3'b000, 32'h0})
            $display("FAIL tmo_after: got %b %b %b %h want 0 0 0 0", mem_valid, err, ram_req,
                     mem_rdata);
        else n_pass++;
        ram_ready = 1'b0;
    endtask

    task automatic test_reset_wait();
        if_req = 1'b1; if_addr = 32'h30;
        step();
        n_checks++;
        if (ram_req !== 1'b1) $display("FAIL rw_c1: got %b want 1", ram_req);
        else n_pass++;
        step();
        rst = 1'b1; ram_ready = 1'b1; ram_rdata = 32'hBAD;
        step();
        n_checks++;
        if ({ram_req, if_valid, stall_if, if_rdata} !== {3'b000, 32'h0})
            $display("FAIL rw_abort: got %b %b %b %h want 0 0 0 0", ram_req, if_valid, stall_if,
                     if_rdata);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if ({ram_req, if_valid, ram_addr} !== {2'b10, 32'h30})
            $display("FAIL rw_regrant: got %b %b %h want 1 0 30", ram_req, if_valid, ram_addr);
        else n_pass++;
        ram_ready = 1'b1; ram_rdata = 32'hABCD;
        step();
        ram_ready = 1'b0;
        n_checks++;
        if ({if_valid, if_rdata} !== {1'b1, 32'hABCD})
            $display("FAIL rw_done: got %b %h want 1 abcd", if_valid, if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [W-1:0] if_q [$];
        bit           mq_we [$];
        logic [W-1:0] mq_addr [$];
        logic [W-1:0] mq_data [$];
        int unsigned  rsp_k [$];
        bit           if_act = 1'b0, mem_act = 1'b0, t_live = 1'b0;
        bit           t_mem, t_we, t_err, cur_we, e_req, e_ifv, e_mv, e_err;
        int unsigned  starve = 0, cyc_free = 0, t_g = 0, t_r = 0, k, wl, wcnt = 0, kcur = 1;
        logic [W-1:0] t_addr, t_wdata, t_rdata, cur_iaddr, cur_maddr, cur_mdata;
        logic [W-1:0] e_if_rdata = '0, e_mem_rdata = '0;
        for (int i = 0; i < 40; i++) begin
            if_q.push_back(32'($urandom_range(0, 15) * 4));
            mq_we.push_back(1'($urandom_range(0, 1)));
            mq_addr.push_back(32'($urandom_range(0, 15) * 4));
            mq_data.push_back($urandom);
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (t_live && c == t_r) begin
                if (!t_mem) e_if_rdata = t_rdata;
                else if (!t_we) e_mem_rdata = t_rdata;
            end
            e_req = t_live && c > t_g && c < t_r;
            e_ifv = t_live && c == t_r && !t_mem;
            e_mv  = t_live && c == t_r && t_mem;
            e_err = t_live && c == t_r && t_err;
            n_checks++;
            if ({ram_req, if_valid, mem_valid, err} !== {e_req, e_ifv, e_mv, e_err})
                $display("FAIL rnd_ctrl c%0d: got %b want %b", c,
                         {ram_req, if_valid, mem_valid, err}, {e_req, e_ifv, e_mv, e_err});
            else n_pass++;
            if (e_req) begin
                n_checks++;
                if ({ram_we, ram_addr} !== {t_we, t_addr} || (t_we && ram_wdata !== t_wdata))
                    $display("FAIL rnd_bus c%0d: got %b %h %h want %b %h %h", c, ram_we,
                             ram_addr, ram_wdata, t_we, t_addr, t_wdata);
                else n_pass++;
            end
            n_checks++;
            if ({if_rdata, mem_rdata} !== {e_if_rdata, e_mem_rdata})
                $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", c, if_rdata, mem_rdata,
                         e_if_rdata, e_mem_rdata);
            else n_pass++;
            if (t_live && c == t_r) begin
                t_live = 1'b0;
                if (t_mem) mem_act = 1'b0;
                else if_act = 1'b0;
            end
            // Memory responder: answers after the drawn delay, babbles when not requested.
            if (ram_req) begin
                wcnt++;
                if (wcnt == 1) kcur = (rsp_k.size() > 0) ? rsp_k.pop_front() : 1;
                ram_ready = (wcnt == kcur);
                ram_rdata = $urandom;
                if (ram_ready && ram_we) rmem[ram_addr] = ram_wdata;
                else if (ram_ready)
                    ram_rdata = rmem.exists(ram_addr) ? rmem[ram_addr] : init_word(ram_addr);
            end else begin
                wcnt = 0;
                ram_ready = 1'($urandom_range(0, 1));
                ram_rdata = $urandom;
            end
            if (!if_act && if_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                if_act = 1'b1;
                cur_iaddr = if_q.pop_front();
            end
            if (!mem_act && mq_we.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_act = 1'b1;
                cur_we = mq_we.pop_front();
                cur_maddr = mq_addr.pop_front();
                cur_mdata = mq_data.pop_front();
            end
            if_req = if_act;
            if_addr = if_act ? cur_iaddr : $urandom;
            mem_r_en = mem_act && !cur_we;
            mem_w_en = mem_act && cur_we;
            mem_addr = mem_act ? cur_maddr : $urandom;
            mem_wdata = mem_act ? cur_mdata : $urandom;
            if (c >= cyc_free && (if_act || mem_act)) begin
                t_mem = mem_act && (!if_act || starve < SLIM);
                starve = (t_mem && if_act) ? starve + 1 : 0;
                t_we = t_mem && cur_we;
                t_addr = t_mem ? cur_maddr : cur_iaddr;
                t_wdata = cur_mdata;
                k = $urandom_range(0, 9);
                k = (k == 0 && !t_we) ? TMO + 5 : (k == 1) ? TMO : $urandom_range(1, 4);
                rsp_k.push_back(k);
                t_err = k > TMO;
                wl = t_err ? TMO : k;
                t_g = c;
                t_r = c + wl + 1;
                cyc_free = t_r + 1;
                t_live = 1'b1;
                t_rdata = '0;
                if (t_we) mmem[t_addr] = t_wdata;
                else if (!t_err) t_rdata = mmem.exists(t_addr) ? mmem[t_addr] : init_word(t_addr);
            end
            #1;
            n_checks++;
            if ({stall_if, stall_mem} !== {if_act && !e_ifv, mem_act && !e_mv})
                $display("FAIL rnd_stall c%0d: got %b%b want %b%b", c, stall_if, stall_mem,
                         if_act && !e_ifv, mem_act && !e_mv);
            else n_pass++;
            if (if_q.size() == 0 && mq_we.size() == 0 && !if_act && !mem_act && !t_live) break;
            step();
        end
        n_checks++;
        if (if_q.size() != 0 || mq_we.size() != 0 || if_act || mem_act || t_live)
            $display("FAIL rnd_drain: got %0d IF + %0d MEM left want 0", if_q.size(),
                     mq_we.size());
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_if_only();
        test_simultaneous();
        test_store();
        test_starvation();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
